// File: rtl/leaf_result_tx.sv
// Leaf result buffer: compacts up to three lane results per beat into a ring
// buffer and serializes each entry as a 6-byte frame (0xA5 header + 5 data bytes).
module leaf_result_tx #(
  parameter int DEPTH = 8,
  parameter int RW    = 35
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               res_valid,
  input  logic [RW-1:0]            res_data0,
  input  logic [RW-1:0]            res_data1,
  input  logic [RW-1:0]            res_data2,
  output logic                     res_ready,
  input  logic                     clear,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [7:0]    HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [2:0]      idx_r, idx_s;
  logic [RW-1:0]   hold_r, hold_s;
  logic [7:0]      tx_data_r, tx_data_s;
  logic            tx_valid_r, tx_valid_s;
  logic            overflow_r;
  logic [RW-1:0]   mem_r [DEPTH];

  logic [CW-1:0]   space_s, push_n_s;
  logic [AW-1:0]   addr1_s, addr2_s, wr_next_s;
  logic            ready_s, push_s, pop_s, avail_s;

  // Little-endian byte of the held entry; byte 4 carries the zero-padded top bits.
  function automatic logic [7:0] data_byte(input logic [RW-1:0] h, input logic [2:0] idx);
    logic [39:0] ext;
    ext = 40'(h);
    case (idx)
      3'd0:    data_byte = ext[7:0];
      3'd1:    data_byte = ext[15:8];
      3'd2:    data_byte = ext[23:16];
      3'd3:    data_byte = ext[31:24];
      3'd4:    data_byte = ext[39:32];
      default: data_byte = 8'h00;
    endcase
  endfunction

  assign space_s   = DEPTH_C - count_r;
  assign ready_s   = reset && (space_s >= CW'(3));
  assign push_s    = ready_s && (res_valid != 3'b000) && !clear;
  // A clear flushes the queue before the transmitter may take from it.
  assign avail_s   = (count_r != '0) && !clear;
  assign push_n_s  = CW'(res_valid[0]) + CW'(res_valid[1]) + CW'(res_valid[2]);
  assign addr1_s   = wr_ptr_r + AW'(res_valid[0]);
  assign addr2_s   = addr1_s + AW'(res_valid[1]);
  assign wr_next_s = addr2_s + AW'(res_valid[2]);

  assign res_ready = ready_s;
  assign tx_data   = tx_data_r;
  assign tx_valid  = tx_valid_r;
  assign count     = count_r;
  assign overflow  = overflow_r;

  // Frame sequencer: next state, holding register and outgoing byte.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    hold_s     = hold_r;
    tx_data_s  = tx_data_r;
    tx_valid_s = tx_valid_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (avail_s) begin
          hold_s     = mem_r[rd_ptr_r];
          pop_s      = 1'b1;
          idx_s      = 3'd0;
          tx_valid_s = 1'b1;
          tx_data_s  = HDR_BYTE;
          state_s    = HDR;
        end else begin
          tx_valid_s = 1'b0;
          tx_data_s  = 8'h00;
        end
      end
      HDR: begin
        if (tx_ready) begin
          idx_s     = 3'd0;
          tx_data_s = data_byte(hold_r, 3'd0);
          state_s   = DATA;
        end else begin
          state_s = HDR;
        end
      end
      DATA: begin
        if (tx_ready) begin
          if (idx_r < 3'd4) begin
            idx_s     = idx_r + 3'd1;
            tx_data_s = data_byte(hold_r, idx_r + 3'd1);
          end else if (avail_s) begin
            hold_s    = mem_r[rd_ptr_r];
            pop_s     = 1'b1;
            idx_s     = 3'd0;
            tx_data_s = HDR_BYTE;
            state_s   = HDR;
          end else begin
            idx_s      = 3'd0;
            tx_valid_s = 1'b0;
            tx_data_s  = 8'h00;
            state_s    = IDLE;
          end
        end else begin
          state_s = DATA;
        end
      end
      default: begin
        state_s    = IDLE;
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
      end
    endcase
  end

  // State, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      idx_r      <= 3'd0;
      hold_r     <= '0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      hold_r     <= hold_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      rd_ptr_r   <= rd_ptr_r + AW'(pop_s);
      if (clear) begin
        count_r    <= '0;
        wr_ptr_r   <= rd_ptr_r;
        overflow_r <= 1'b0;
      end else begin
        count_r <= count_r + (push_s ? push_n_s : CW'(0)) - CW'(pop_s);
        if (push_s) begin
          wr_ptr_r <= wr_next_s;
        end
        if ((res_valid != 3'b000) && !ready_s) begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  // Result storage, lanes packed into consecutive slots.
  always_ff @(posedge clk) begin
    if (push_s) begin
      if (res_valid[0]) mem_r[wr_ptr_r] <= res_data0;
      if (res_valid[1]) mem_r[addr1_s]  <= res_data1;
      if (res_valid[2]) mem_r[addr2_s]  <= res_data2;
    end
  end

endmodule
